// File: rtl/minbd_pkg.sv
// Shared MinBD side-buffer definitions: flit/starve/statistic widths and a
// saturating add helper for the optional MINBD_SB_STATS_EN counters.
package minbd_pkg;

    localparam int unsigned FLIT_W_DEF   = 64;
    localparam int unsigned STARVE_CNT_W = 8;
    localparam int unsigned STAT_W       = 16;

    typedef logic [FLIT_W_DEF-1:0]   flit_t;
    typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;
    typedef logic [STAT_W-1:0]       stat_t;

    // Per-cycle write arbitration result; redirect always wins a single slot.
    typedef struct packed {
        logic acc_redirect;
        logic acc_eject;
        logic drop;
    } wr_dec_t;

    function automatic stat_t stat_add(stat_t v, logic [1:0] inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, v} + {{(STAT_W-1){1'b0}}, inc};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/minbd_starve_ctr.sv
// Saturating starvation counter for the side buffer head; starve is a
// registered threshold compare that drops the cycle after a pop.
module minbd_starve_ctr
    import minbd_pkg::*;
#(
    parameter int unsigned STARVE_TH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic empty,
    input  logic inject_gnt,
    output logic starve
);

    starve_cnt_t cnt_q, cnt_d;
    logic        starve_d;

    always_comb begin
        cnt_d = cnt_q;
        if (empty || inject_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != {STARVE_CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
        starve_d = (cnt_d >= STARVE_CNT_W'(STARVE_TH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            starve <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            starve <= starve_d;
        end
    end

endmodule

// File: rtl/minbd_side_buffer_gen.sv
// MinBD side buffer: dual-write (redirect before eject), single-read FWFT FIFO
// with sticky overflow and starvation flag. Define MINBD_SB_STATS_EN for stats.
module minbd_side_buffer_gen
    import minbd_pkg::*;
#(
    parameter int unsigned FLIT_W    = FLIT_W_DEF,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STARVE_TH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_W-1:0]          din_redirect,
    input  logic                       redirect_gnt,
    input  logic [FLIT_W-1:0]          din_eject,
    input  logic                       eject_vld,
    output logic [FLIT_W-1:0]          dout_inject,
    input  logic                       inject_gnt,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       starve,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output stat_t                      stat_wr,
    output stat_t                      stat_drop,
    output stat_t                      stat_starve_cyc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, eject_ptr;
    logic [CNT_W-1:0]  count_q, count_d, space;
    logic              overflow_q, overflow_d;
    logic              pop;
    logic [1:0]        n_wr;
    wr_dec_t           dec;

    always_comb begin
        pop   = inject_gnt && (count_q != '0);
        // A same-cycle pop frees a slot for this cycle's writes.
        space = CNT_W'(DEPTH) - count_q + {{(CNT_W-1){1'b0}}, pop};

        dec.acc_redirect = redirect_gnt && (space != '0);
        dec.acc_eject    = eject_vld &&
                           (space > (dec.acc_redirect ? CNT_W'(1) : CNT_W'(0)));
        dec.drop         = (redirect_gnt && !dec.acc_redirect) ||
                           (eject_vld && !dec.acc_eject);

        n_wr       = {1'b0, dec.acc_redirect} + {1'b0, dec.acc_eject};
        eject_ptr  = dec.acc_redirect ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(n_wr) - CNT_W'(pop);
        overflow_d = overflow_q | dec.drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy and the empty gate on dout hide stale data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (dec.acc_redirect) mem[wr_ptr_q] <= din_redirect;
            if (dec.acc_eject)    mem[eject_ptr] <= din_eject;
        end
    end

    assign count       = count_q;
    assign overflow    = overflow_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(DEPTH - 1));
    assign dout_inject = empty ? '0 : mem[rd_ptr_q];

    minbd_starve_ctr #(
        .STARVE_TH (STARVE_TH)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .empty      (empty),
        .inject_gnt (inject_gnt),
        .starve     (starve)
    );

`ifdef MINBD_SB_STATS_EN
    stat_t      stat_wr_q, stat_drop_q, stat_starve_q;
    logic [1:0] n_drop;

    assign n_drop = {1'b0, redirect_gnt && !dec.acc_redirect} +
                    {1'b0, eject_vld && !dec.acc_eject};

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_q     <= '0;
            stat_drop_q   <= '0;
            stat_starve_q <= '0;
        end else begin
            stat_wr_q     <= stat_add(stat_wr_q, n_wr);
            stat_drop_q   <= stat_add(stat_drop_q, n_drop);
            stat_starve_q <= stat_add(stat_starve_q, {1'b0, starve});
        end
    end

    assign stat_wr         = stat_wr_q;
    assign stat_drop       = stat_drop_q;
    assign stat_starve_cyc = stat_starve_q;
`else
    assign stat_wr         = '0;
    assign stat_drop       = '0;
    assign stat_starve_cyc = '0;
`endif

endmodule

// File: tb/tb_minbd_side_buffer_gen.sv
// Directed bench for minbd_side_buffer_gen (DEPTH=4, STARVE_TH=8): vector
// table for fill/pop/dual-write, then hand sequences for reset, drop, starve, wrap.
module tb_minbd_side_buffer_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din_redirect, din_eject, dout_inject;
    logic        redirect_gnt, eject_vld, inject_gnt;
    logic        full, empty, almost_full, starve, overflow;
    logic [2:0]  count;
    logic [15:0] stat_wr, stat_drop, stat_starve_cyc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    minbd_side_buffer_gen #(
        .FLIT_W    (64),
        .DEPTH     (4),
        .STARVE_TH (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .din_redirect    (din_redirect),
        .redirect_gnt    (redirect_gnt),
        .din_eject       (din_eject),
        .eject_vld       (eject_vld),
        .dout_inject     (dout_inject),
        .inject_gnt      (inject_gnt),
        .full            (full),
        .empty           (empty),
        .almost_full     (almost_full),
        .starve          (starve),
        .count           (count),
        .overflow        (overflow),
        .stat_wr         (stat_wr),
        .stat_drop       (stat_drop),
        .stat_starve_cyc (stat_starve_cyc)
    );

    typedef struct {
        logic        rg;
        logic [63:0] dr;
        logic        ev;
        logic [63:0] de;
        logic        ig;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ovf;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one clock, sample 1 time unit after the edge, then idle inputs.
    task automatic cyc(input logic rg, input logic [63:0] dr, input logic ev,
                       input logic [63:0] de, input logic ig);
        redirect_gnt = rg;
        din_redirect = dr;
        eject_vld    = ev;
        din_eject    = de;
        inject_gnt   = ig;
        @(posedge clk);
        #1;
        redirect_gnt = 1'b0;
        eject_vld    = 1'b0;
        inject_gnt   = 1'b0;
    endtask

    task automatic push(input logic [63:0] d);
        cyc(1'b1, d, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic pop_one();
        cyc(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    endtask

    initial begin
        rst          = 1'b1;
        redirect_gnt = 1'b0;
        eject_vld    = 1'b0;
        inject_gnt   = 1'b0;
        din_redirect = '0;
        din_eject    = '0;

        //           rg    dr      ev    de      ig    cnt   full  empty af    ovf   dout
        vecs[0]  = '{1'b1, 64'hA1, 1'b0, 64'h0,  1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA1};
        vecs[1]  = '{1'b1, 64'hA2, 1'b0, 64'h0,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA1};
        vecs[2]  = '{1'b1, 64'hA3, 1'b0, 64'h0,  1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA1};
        vecs[3]  = '{1'b1, 64'hA4, 1'b0, 64'h0,  1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA1};
        vecs[4]  = '{1'b1, 64'hA5, 1'b0, 64'h0,  1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA2};
        vecs[5]  = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA3};
        vecs[6]  = '{1'b1, 64'hB1, 1'b1, 64'hE1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 64'hA3};
        vecs[7]  = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA4};
        vecs[8]  = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA5};
        vecs[9]  = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hB1};
        vecs[10] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[11] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[12] = '{1'b0, 64'h0,  1'b1, 64'hE2, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hE2};
        vecs[13] = '{1'b1, 64'hC3, 1'b1, 64'hE3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 64'hE2};
        vecs[14] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 64'hC3};
        vecs[15] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hE3};
        vecs[16] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_dout", dout_inject, 64'h0);
        chk("rst_starve", 64'(starve), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_stats", {16'h0, stat_wr, stat_drop, stat_starve_cyc}, 64'h0);

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].rg, vecs[i].dr, vecs[i].ev, vecs[i].de, vecs[i].ig);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i), 64'(full), 64'(vecs[i].full));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].empty));
            chk($sformatf("v%0d_af", i), 64'(almost_full), 64'(vecs[i].af));
            chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
            chk($sformatf("v%0d_dout", i), dout_inject, vecs[i].dout);
        end

        // Reset mid-fill with a write and a pop in the reset cycle.
        push(64'hD1);
        push(64'hD2);
        push(64'hD3);
        chk("mid_count3", 64'(count), 64'd3);
        rst = 1'b1;
        cyc(1'b1, 64'hDD, 1'b1, 64'hDE, 1'b1);
        rst = 1'b0;
        chk("mid_empty", 64'(empty), 64'd1);
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_dout", dout_inject, 64'h0);
        chk("mid_starve", 64'(starve), 64'd0);
        chk("mid_ovf", 64'(overflow), 64'd0);
        chk("mid_stats", {16'h0, stat_wr, stat_drop, stat_starve_cyc}, 64'h0);

        // Write while full with no pop: dropped, contents unchanged.
        push(64'hF1);
        push(64'hF2);
        push(64'hF3);
        push(64'hF4);
        chk("full_ovf_before", 64'(overflow), 64'd0);
        push(64'hF5);
        chk("full_drop_count", 64'(count), 64'd4);
        chk("full_drop_ovf", 64'(overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("full_order%0d", i), dout_inject, 64'hF0 + 64'(i));
            pop_one();
        end
        chk("full_drained", 64'(empty), 64'd1);

        // Starvation: one entry, 8 idle cycles, then a single pop.
        push(64'h51);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
            if (i == 7) chk("starve_at7", 64'(starve), 64'd0);
        end
        chk("starve_at8", 64'(starve), 64'd1);
        pop_one();
        chk("starve_clear", 64'(starve), 64'd0);
        chk("starve_empty", 64'(empty), 64'd1);

        // Wrap: 10 push/pop pairs, head always the previous push.
        push(64'h100);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 64'h100 + 64'(i), 1'b0, 64'h0, 1'b1);
            chk($sformatf("wrap%0d_dout", i), dout_inject, 64'h100 + 64'(i));
            chk($sformatf("wrap%0d_count", i), 64'(count), 64'd1);
        end
        pop_one();
        chk("wrap_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minbd_side_buffer_gen.md
MINBD_SIDE_BUFFER_GEN -- requirements
Module: minbd_side_buffer_gen

Interface
REQ-001 SHALL have parameter FLIT_W, default 64: flit width in bits, matching the external flit width.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; power of two, >=2.
REQ-003 SHALL have parameter STARVE_TH, default 8: consecutive non-served cycles before starve asserts; range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port din_redirect, input, FLIT_W: flit redirected from a full-channel stage.
REQ-007 SHALL have port redirect_gnt, input, 1: write request for din_redirect.
REQ-008 SHALL have port din_eject, input, FLIT_W: deflected flit picked by the eject-to-side-buffer stage.
REQ-009 SHALL have port eject_vld, input, 1: write request for din_eject.
REQ-010 SHALL have port dout_inject, output, FLIT_W: head entry, first-word-fall-through.
REQ-011 SHALL have port inject_gnt, input, 1: pops the head entry.
REQ-012 SHALL have ports full, empty, almost_full, starve, output, 1 each: status flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have port overflow, output, 1: sticky flag set when a write is dropped.

Function
REQ-015 SHALL make written data visible on dout_inject one cycle after the write when the buffer was empty.
REQ-016 SHALL compute free space as DEPTH-count+inject_gnt, so a pop frees a slot for a same-cycle push.
REQ-017 SHALL, on simultaneous writes, store din_redirect before din_eject; if only one slot is free, drop din_eject and set overflow.
REQ-018 SHALL, if space is 0 and a write arrives, drop the write and set overflow; stored contents SHALL be unchanged.
REQ-019 SHALL ignore inject_gnt while empty; count SHALL not underflow and the pointers SHALL not move.
REQ-020 SHALL wrap the read and write pointers modulo DEPTH.
REQ-021 SHALL update count as count+writes_accepted-pop, within 0..DEPTH.
REQ-022 SHALL drive full=(count==DEPTH), almost_full=(count>=DEPTH-1) and empty=(count==0), all decoded from registered count.
REQ-023 SHALL run an 8-bit saturating starve counter that increments each cycle with ~empty && ~inject_gnt and clears on inject_gnt or empty.
REQ-024 SHALL assert starve, registered, when the starve counter >= STARVE_TH, and deassert it the cycle after a pop.
REQ-025 SHALL keep dout_inject at 0 while empty.

Reset
REQ-026 SHALL, with rst high at a clk edge, clear the pointers, count, starve counter, starve and overflow, giving empty=1, full=0, almost_full=0 and dout_inject=0.
REQ-027 SHALL, on reset mid-operation, discard stored flits; writes and pops in the reset cycle SHALL be ignored.

Configuration
REQ-028 SHALL, with MINBD_SB_STATS_EN defined, add 16-bit saturating counters stat_wr, stat_drop and stat_starve_cyc, readable on outputs of the same names and cleared by rst.
REQ-029 SHALL, without MINBD_SB_STATS_EN, tie those outputs to 0 and infer no counter logic.

Structure
REQ-030 SHALL place FLIT_W defaults, the flit struct widths and starve counter width in shared package minbd_pkg.
REQ-031 SHALL implement the starve counter and threshold compare in sub-module minbd_starve_ctr.

Verification (DEPTH=4, STARVE_TH=8)
REQ-032 SHALL cover fill: 4 single redirect writes -> count=4, full=1, almost_full=1 after the 3rd write, overflow=0.
REQ-033 SHALL cover dual write with count=3: redirect_gnt and eject_vld together -> redirect flit stored, count=4, overflow=1, din_eject lost.
REQ-034 SHALL cover pop plus push at full: count=4, inject_gnt and redirect_gnt together -> count stays 4, FIFO order preserved, overflow=0.
REQ-035 SHALL cover starvation: 1 entry and no inject_gnt for 8 cycles -> starve=1 in the cycle after the 8th; a single inject_gnt -> starve=0 the next cycle.
REQ-036 SHALL cover wrap: 10 push/pop pairs -> output order equals input order and pointers wrap with no loss.
REQ-037 SHALL cover reset mid-fill: count=3, rst=1 for 1 cycle -> empty=1, count=0, dout_inject=0, starve=0; stats are 0 if MINBD_SB_STATS_EN is defined.
